// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
// Pops words from a synchronous FIFO (rd / empty / registered rdata) and
// presents them as a valid/ready stream at one word per cycle. A 2-entry
// skid buffer absorbs the FIFO's one-cycle read latency so that reads can
// be issued speculatively while the consumer may still stall.
// Optional feature macro: STREAM_LAST_EN -- when defined, out_last marks
// every PKT_LEN-th accepted beat; when undefined, out_last is tied to 0.
module fifo_stream_adapter #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      beat_count
);

    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] beat_count_q, beat_count_d;
    logic        pop;
    logic [2:0]  occupancy;

    // Stream handshake and read issue: a read is only launched when the
    // word it returns is guaranteed a free buffer slot, counting the word
    // already in flight and the slot freed by this cycle's pop.
    always_comb begin
        out_valid = (count_q != 2'd0);
        pop       = out_valid && out_ready;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd   = reset_n && !fifo_empty && (occupancy < 3'd2);
    end

    // Next-state for pointers, occupancy and the beat counter.
    always_comb begin
        inflight_d   = fifo_rd;
        tail_d       = tail_q ^ inflight_q;
        head_d       = head_q ^ pop;
        count_d      = count_q;
        beat_count_d = beat_count_q + {15'd0, pop};
        case ({inflight_q, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            beat_count_q <= 16'd0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            beat_count_q <= beat_count_d;
        end
    end

    // Skid buffer entries: the returning FIFO word lands in the slot at tail.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q, entry_d;

        // Capture the in-flight word when this slot is the tail.
        always_comb begin
            entry_d = entry_q;
            if (inflight_q && (tail_q == 1'(gi))) begin
                entry_d = fifo_rdata;
            end
        end

        // Entry storage; cleared on reset so no stale word survives.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end
    end

    assign out_data   = head_q ? g_entry[1].entry_q : g_entry[0].entry_q;
    assign beat_count = beat_count_q;

`ifdef STREAM_LAST_EN
    logic [15:0] pkt_idx_q, pkt_idx_d;

    // Packet position: counts accepted beats 0..PKT_LEN-1 and wraps.
    always_comb begin
        pkt_idx_d = pkt_idx_q;
        if (pop) begin
            pkt_idx_d = (pkt_idx_q == LAST_IDX) ? 16'd0 : pkt_idx_q + 16'd1;
        end
    end

    // Packet position register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_idx_q <= 16'd0;
        end else begin
            pkt_idx_q <= pkt_idx_d;
        end
    end

    assign out_last = out_valid && (pkt_idx_q == LAST_IDX);
`else
    assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Testbench for fifo_stream_adapter: a queue-based FIFO model drives the
// read side, and a negedge monitor compares the stream against the words
// pushed into the FIFO, the accepted-beat count and the packet position.
module tb_fifo_stream_adapter;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;

    logic             clk;
    logic             reset_n;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [15:0]      beat_count;

    fifo_stream_adapter #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_rdata (fifo_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];

    // Samples taken by tick() on the negedge
    logic             s_rd, s_valid, s_ready, s_last;
    logic [WIDTH-1:0] s_data;
    int               beats_seen = 0;

    // Reference model state (monitor)
    int unsigned      issued_total   = 0;
    int unsigned      accepted_total = 0;
    int unsigned      arrived        = 0;
    logic             rd_d1          = 1'b0;
    logic             prev_hold      = 1'b0;
    logic [WIDTH-1:0] prev_data      = '0;
    logic             prev_last      = 1'b0;

    // Monitor: words arrive two cycles after their read; the stream must
    // deliver exactly the pushed sequence, and stalled beats must hold.
    always @(negedge clk) begin
        if (!reset_n) begin
            issued_total   = 0;
            accepted_total = 0;
            arrived        = 0;
            rd_d1          = 1'b0;
            prev_hold      = 1'b0;
        end else begin
            logic exp_valid, exp_last;
            exp_valid = (arrived > accepted_total);
`ifdef STREAM_LAST_EN
            exp_last = exp_valid && ((accepted_total % PKT_LEN) == PKT_LEN - 1);
`else
            exp_last = 1'b0;
`endif
            tests++;
            if (out_valid !== exp_valid) begin
                fails++;
                $display("FAIL mon_valid: got %b want %b", out_valid, exp_valid);
            end
            tests++;
            if (fifo_rd === 1'b1 && fifo_empty === 1'b1) begin
                fails++;
                $display("FAIL mon_rd_empty: got fifo_rd=1 want 0 while empty");
            end
            tests++;
            if (issued_total - accepted_total > 2) begin
                fails++;
                $display("FAIL mon_occupancy: got %0d want <=2", issued_total - accepted_total);
            end
            tests++;
            if (beat_count !== 16'(accepted_total)) begin
                fails++;
                $display("FAIL mon_beat_count: got %0d want %0d", beat_count, 16'(accepted_total));
            end
            tests++;
            if (out_last !== exp_last) begin
                fails++;
                $display("FAIL mon_last: got %b want %b", out_last, exp_last);
            end
            if (prev_hold) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    fails++;
                    $display("FAIL mon_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_data: got %h want no word", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        fails++;
                        $display("FAIL mon_data: got %h want %h", out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                accepted_total++;
            end
            prev_hold    = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data    = out_data;
            prev_last    = out_last;
            arrived      = arrived + 32'(rd_d1);
            rd_d1        = fifo_rd;
            issued_total = issued_total + 32'(fifo_rd);
        end
    end

    // One clock of the FIFO model: sample at negedge, update read data after posedge.
    task automatic tick();
        @(negedge clk);
        s_rd    = fifo_rd;
        s_valid = out_valid;
        s_ready = out_ready;
        s_data  = out_data;
        s_last  = out_last;
        if (s_valid && s_ready) begin
            beats_seen++;
            $display("[TB] beat %0d data=%h last=%b t=%0t", beats_seen, s_data, s_last, $time);
        end
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        fifo_empty = 1'b0;   // rd must stay low while reset is held
        @(negedge clk);
        tests++;
        if (fifo_rd !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            out_last !== 1'b0 || beat_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_values: got rd=%b v=%b d=%h l=%b bc=%0d want all 0",
                     fifo_rd, out_valid, out_data, out_last, beat_count);
        end
        fifo_empty = 1'b1;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] exp_w [3];
        int n;
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(exp_w[i]);
        n = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) begin
                tests++;
                if (s_rd !== 1'b1) begin
                    fails++;
                    $display("FAIL latency_rd0: got %b want 1", s_rd);
                end
            end
            if (s_valid && s_ready) begin
                tests++;
                if (n > 2 || c != 2 + n || s_data !== exp_w[n > 2 ? 2 : n]) begin
                    fails++;
                    $display("FAIL latency_beat: got cycle %0d data %h want cycle %0d", c, s_data, 2 + n);
                end
                n++;
            end
        end
        tests++;
        if (n != 3 || beat_count !== 16'd3) begin
            fails++;
            $display("FAIL latency_count: got beats %0d bc %0d want 3", n, beat_count);
        end
    endtask

    task automatic test_backpressure();
        int rd_pulses, first, last, n;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i));
        rd_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_rd) rd_pulses++;
        end
        tests++;
        if (s_valid !== 1'b1 || s_data !== 8'h00) begin
            fails++;
            $display("FAIL bp_hold: got v=%b d=%h want v=1 d=00", s_valid, s_data);
        end
        tests++;
        if (rd_pulses != 2) begin
            fails++;
            $display("FAIL bp_rd_pulses: got %0d want 2", rd_pulses);
        end
        out_ready = 1'b1;
        n = 0; first = -1; last = -1;
        for (int c = 0; c < 30 && n < 8; c++) begin
            tick();
            if (s_valid && s_ready) begin
                if (first < 0) first = c;
                last = c;
                n++;
            end
        end
        tests++;
        if (n != 8 || first != 0 || last - first != 7) begin
            fails++;
            $display("FAIL bp_drain: got %0d beats over cycles %0d..%0d want 8 contiguous from 0", n, first, last);
        end
    endtask

    task automatic test_random();
        int pushed, got, cyc;
        pushed = 0; got = 0; cyc = 0;
        while (got < 200 && cyc < 4000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 9) < 6) begin
                push(8'($urandom));
                pushed++;
            end
            tick();
            if (s_valid && s_ready) got++;
            cyc++;
        end
        tests++;
        if (got != 200 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL random_drain: got %0d beats, %0d left want 200, 0", got, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (fifo_rd !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            out_last !== 1'b0 || beat_count !== 16'd0) begin
            fails++;
            $display("FAIL midreset_values: got rd=%b v=%b d=%h l=%b bc=%0d want all 0",
                     fifo_rd, out_valid, out_data, out_last, beat_count);
        end
        fifo_q.delete();
        exp_q.delete();
        fifo_rdata = '0;
        fifo_empty = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (s_valid !== 1'b0) begin
                fails++;
                $display("FAIL midreset_stale: got v=%b d=%h want v=0", s_valid, s_data);
            end
        end
    endtask

    task automatic test_last();
        int n, lasts;
        logic exp_l;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
        n = 0; lasts = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            tick();
            if (s_valid && s_ready) begin
                n++;
`ifdef STREAM_LAST_EN
                exp_l = ((n % PKT_LEN) == 0);
`else
                exp_l = 1'b0;
`endif
                if (s_last) lasts++;
                tests++;
                if (s_last !== exp_l) begin
                    fails++;
                    $display("FAIL last_beat%0d: got %b want %b", n, s_last, exp_l);
                end
            end
        end
        tests++;
`ifdef STREAM_LAST_EN
        if (n != 10 || lasts != 2) begin
`else
        if (n != 10 || lasts != 0) begin
`endif
            fails++;
            $display("FAIL last_total: got %0d beats %0d lasts", n, lasts);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        out_ready  = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_last();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
